// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock with a per-bit valid strobe and a last-bit marker.
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the accepted word) after the data bits of every frame.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   LSB_FIRST  0 = shift MSB first, 1 = shift LSB first
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous active-low reset
//   load_valid    parallel_in holds a word to transmit
//   load_ready    block can accept a word this cycle (decoded from state)
//   parallel_in   word to serialize
//   serial_out    current serial bit
//   serial_valid  serial_out carries a valid bit this cycle
//   last          serial_out is the final bit of the frame
//   busy          a frame is in progress
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             accept;
  logic             data_last;
  logic             final_cycle;
  logic             out_bit;

  // Last data bit of the frame is on the line.
  assign data_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // Final cycle of the frame: the slot in which a follow-on word may load.
`ifdef PISO_PARITY_EN
  assign final_cycle = (state_q == PARITY);
`else
  assign final_cycle = data_last;
`endif

  // Ready is a pure state decode so it never depends on load_valid.
  assign load_ready = (state_q == IDLE) || final_cycle;
  assign accept     = load_valid && load_ready;

  // Bit at the output end of the shift register.
  assign out_bit = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];

  // Output decode from registered state.
  always_comb begin
    serial_out   = 1'b0;
    serial_valid = (state_q != IDLE);
    busy         = (state_q != IDLE);
    last         = final_cycle;
    if (state_q == SHIFT) begin
      serial_out = out_bit;
    end
`ifdef PISO_PARITY_EN
    else if (state_q == PARITY) begin
      serial_out = parity_q;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT;
          shreg_d  = parallel_in;
          cnt_d    = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^parallel_in;
`endif
        end
      end

      SHIFT: begin
        shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
        if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          // Back-to-back: a word accepted on the last bit restarts the frame.
          if (accept) begin
            state_d = SHIFT;
            shreg_d = parallel_in;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d  = SHIFT;
          shreg_d  = parallel_in;
          cnt_d    = '0;
          parity_d = ^parallel_in;
        end else begin
          state_d  = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer (WIDTH=8).
// Two instances share the stimulus: u_msb (LSB_FIRST=0) and u_lsb (LSB_FIRST=1).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [7:0] parallel_in;

  logic m_ready, m_out, m_valid, m_last, m_busy;
  logic l_ready, l_out, l_valid, l_last, l_busy;

  int n_cmp;
  int n_err;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (m_ready),
    .parallel_in  (parallel_in),
    .serial_out   (m_out),
    .serial_valid (m_valid),
    .last         (m_last),
    .busy         (m_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (l_ready),
    .parallel_in  (parallel_in),
    .serial_out   (l_out),
    .serial_valid (l_valid),
    .last         (l_last),
    .busy         (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_busy"},  32'(m_busy),  32'd0);
    chk({tag, "_m_last"},  32'(m_last),  32'd0);
    chk({tag, "_m_out"},   32'(m_out),   32'd0);
    chk({tag, "_m_ready"}, 32'(m_ready), 32'd1);
    chk({tag, "_l_valid"}, 32'(l_valid), 32'd0);
    chk({tag, "_l_ready"}, 32'(l_ready), 32'd1);
  endtask

  // Present a word in IDLE and let the accepting edge pass.
  task automatic load_word(input logic [7:0] w);
    load_valid  = 1'b1;
    parallel_in = w;
    step();
    load_valid  = 1'b0;
    parallel_in = 8'h5A;  // must not disturb the captured word
  endtask

  // Walk one frame that has already been accepted. seq_m/seq_l hold the
  // expected line bits in transmit order, first bit in position 7.
  task automatic check_frame(input string tag, input logic [7:0] seq_m,
                             input logic [7:0] seq_l, input logic par,
                             input bit chk_l, input bit chain,
                             input logic [7:0] nxt, input int poke_at);
    bit fin;
    for (int i = 0; i < 8; i++) begin
      fin = (i == 7) && !PAR_EN;
      chk($sformatf("%s_b%0d_valid", tag, i), 32'(m_valid), 32'd1);
      chk($sformatf("%s_b%0d_busy", tag, i),  32'(m_busy),  32'd1);
      chk($sformatf("%s_b%0d_out", tag, i),   32'(m_out),   32'(seq_m[7-i]));
      chk($sformatf("%s_b%0d_last", tag, i),  32'(m_last),  32'(fin));
      chk($sformatf("%s_b%0d_ready", tag, i), 32'(m_ready), 32'(fin));
      if (chk_l) begin
        chk($sformatf("%s_b%0d_lout", tag, i), 32'(l_out), 32'(seq_l[7-i]));
        chk($sformatf("%s_b%0d_llast", tag, i), 32'(l_last), 32'(fin));
      end
      if (i == poke_at) begin
        load_valid  = 1'b1;
        parallel_in = 8'hFF;
      end
      if (i == poke_at + 1) load_valid = 1'b0;
      if (fin) begin
        load_valid = chain;
        if (chain) parallel_in = nxt;
      end
      step();
    end
    if (PAR_EN) begin
      chk({tag, "_par_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_par_out"},   32'(m_out),   32'(par));
      chk({tag, "_par_last"},  32'(m_last),  32'd1);
      chk({tag, "_par_ready"}, 32'(m_ready), 32'd1);
      if (chk_l) chk({tag, "_par_lout"}, 32'(l_out), 32'(par));
      load_valid = chain;
      if (chain) parallel_in = nxt;
      step();
    end
    if (chain) begin
      load_valid  = 1'b0;
      parallel_in = 8'h5A;
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    load_valid  = 1'b0;
    parallel_in = 8'h00;

    // Reset state.
    step();
    step();
    check_idle("reset");
    reset = 1'b1;
    step();
    check_idle("idle");

    // Single frame 0xB1, both bit orders.
    load_word(8'hB1);
    check_frame("b1", 8'b10110001, 8'b10001101, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    check_idle("b1_end");

    // Back-to-back: 0xB1 held, 0x0F presented on the final frame cycle.
    load_valid  = 1'b1;
    parallel_in = 8'hB1;
    step();
    check_frame("b2b1", 8'b10110001, 8'b10001101, 1'b0, 1'b1, 1'b1, 8'h0F, -1);
    check_frame("b2b2", 8'b00001111, 8'b11110000, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    check_idle("b2b_end");

    // Word offered mid-frame is ignored.
    load_word(8'hB1);
    check_frame("ign", 8'b10110001, 8'b10001101, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    check_idle("ign_end");

    // 0x07: parity bit 1 when enabled.
    load_word(8'h07);
    check_frame("x07", 8'b00000111, 8'b11100000, 1'b1, 1'b1, 1'b0, 8'h00, -1);
    check_idle("x07_end");

    // Reset asserted for half a cycle in the middle of a frame.
    load_word(8'hB1);
    for (int i = 0; i < 4; i++) step();
    chk("mid_valid", 32'(m_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    reset = 1'b1;
    step();
    check_idle("rst_after");
    load_word(8'h0F);
    check_frame("post", 8'b00001111, 8'b11110000, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    check_idle("post_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
